serial_magnitude_comparator: RTL

//  Bit-serial unsigned magnitude comparator: consumes WIDTH operand bit pairs
//  (a_bit, b_bit), MSB first, over a valid/ready handshake.

---
 rtl/comparator_pkg.sv | 16 +
 rtl/bit_compare_cell.sv | 15 +
 rtl/serial_magnitude_comparator.sv | 120 ++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Bit positions of the packed result vector {gt, eq, lt}
  localparam int unsigned RES_W  = 3;
  localparam int unsigned RES_GT = 2;
  localparam int unsigned RES_EQ = 1;
  localparam int unsigned RES_LT = 0;

endpackage : comparator_pkg

// File: rtl/bit_compare_cell.sv
// One MSB-first comparison stage: the first differing bit decides, later bits
// cannot override an existing decision.
module bit_compare_cell (
  input  logic a,
  input  logic b,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  assign gt_out = gt_in | (~gt_in & ~lt_in &  a & ~b);
  assign lt_out = lt_in | (~gt_in & ~lt_in & ~a &  b);

endmodule : bit_compare_cell

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: WIDTH bit pairs MSB first over a
// valid/ready handshake, registered gt/eq/lt flags and a one-cycle done pulse.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               cell_gt, cell_lt;

  bit_compare_cell u_cell (
    .a      (a_bit),
    .b      (b_bit),
    .gt_in  (gt_q),
    .lt_in  (lt_q),
    .gt_out (cell_gt),
    .lt_out (cell_lt)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    res_d   = res_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPARE;
          count_d = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end
      ST_COMPARE: begin
        if (bit_valid) begin
          gt_d = cell_gt;
          lt_d = cell_lt;
          if (count_q == LAST_IDX) begin
            state_d        = ST_DONE;
            count_d        = CNT_MAX;
            done_d         = 1'b1;
            res_d[RES_GT]  = cell_gt;
            res_d[RES_LT]  = cell_lt;
            res_d[RES_EQ]  = ~cell_gt & ~cell_lt;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_COMPARE);
    busy_d  = (state_d == ST_COMPARE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bit_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_gt_b    = res_q[RES_GT];
  assign a_eq_b    = res_q[RES_EQ];
  assign a_lt_b    = res_q[RES_LT];

endmodule : serial_magnitude_comparator
